// File: rtl/fxp_mul_add_unit.sv
// Signed fixed-point multiplier and adder cores with independent launch/done
// handshakes and a shared clock, reset, clear and stall.

// Valid-tagged register pipeline. A stage's data register loads only when a
// valid result enters it, so the last stage holds the most recent result.
module fxp_pipe #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             stall,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   // Advance every stage together unless stalled; reset and clear flush all of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else if (clear) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else if (!stall) begin
         valid_q[0] <= in_valid;
         if (in_valid) data_q[0] <= in_data;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   // The last stage keeps its valid bit through a stall and only reports it
   // once the stall lifts, so every result produces exactly one done pulse.
   always_comb begin
      out_data  = data_q[DEPTH-1];
      out_valid = valid_q[DEPTH-1] & ~stall;
   end

endmodule

module fxp_mul_add_unit #(
   parameter int INPUT_A_WIDTH = 16,
   parameter int INPUT_A_FRAC  = 8,
   parameter int INPUT_B_WIDTH = 16,
   parameter int INPUT_B_FRAC  = 8,
   parameter int OUTPUT_WIDTH  = 16,
   parameter int OUTPUT_FRAC   = 8,
   parameter int MUL_DELAY     = 3,
   parameter int ADD_DELAY     = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clear,
   input  logic                            stall,
   input  logic                            mul_en,
   input  logic signed [INPUT_A_WIDTH-1:0] mul_a,
   input  logic signed [INPUT_B_WIDTH-1:0] mul_b,
   output logic signed [OUTPUT_WIDTH-1:0]  mul_out,
   output logic                            mul_done,
   input  logic                            add_en,
   input  logic signed [INPUT_A_WIDTH-1:0] add_a,
   input  logic signed [INPUT_B_WIDTH-1:0] add_b,
   output logic signed [OUTPUT_WIDTH-1:0]  add_out,
   output logic                            add_done
);

   localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

   // Multiplier geometry: full product, rescale shift, and a working width
   // wide enough that the left shift cannot overflow before saturation.
   localparam int MUL_PW  = INPUT_A_WIDTH + INPUT_B_WIDTH;
   localparam int MUL_PF  = INPUT_A_FRAC + INPUT_B_FRAC;
   localparam int MUL_RSH = (MUL_PF > OUTPUT_FRAC) ? MUL_PF - OUTPUT_FRAC : 0;
   localparam int MUL_LSH = (OUTPUT_FRAC > MUL_PF) ? OUTPUT_FRAC - MUL_PF : 0;
   localparam int MUL_XW  = (((MUL_PW + MUL_LSH) > OUTPUT_WIDTH) ? (MUL_PW + MUL_LSH) : OUTPUT_WIDTH) + 1;

   // Adder geometry: align both operands to the finer fraction, one guard bit.
   localparam int ADD_FM  = (INPUT_A_FRAC > INPUT_B_FRAC) ? INPUT_A_FRAC : INPUT_B_FRAC;
   localparam int ADD_ASH = ADD_FM - INPUT_A_FRAC;
   localparam int ADD_BSH = ADD_FM - INPUT_B_FRAC;
   localparam int ADD_SW  = (((INPUT_A_WIDTH + ADD_ASH) > (INPUT_B_WIDTH + ADD_BSH)) ?
                             (INPUT_A_WIDTH + ADD_ASH) : (INPUT_B_WIDTH + ADD_BSH)) + 1;
   localparam int ADD_RSH = (ADD_FM > OUTPUT_FRAC) ? ADD_FM - OUTPUT_FRAC : 0;
   localparam int ADD_LSH = (OUTPUT_FRAC > ADD_FM) ? OUTPUT_FRAC - ADD_FM : 0;
   localparam int ADD_XW  = (((ADD_SW + ADD_LSH) > OUTPUT_WIDTH) ? (ADD_SW + ADD_LSH) : OUTPUT_WIDTH) + 1;

   logic signed [MUL_PW-1:0]       mul_prod;
   logic signed [MUL_XW-1:0]       mul_ext;
   logic signed [MUL_XW-1:0]       mul_scaled;
   logic signed [OUTPUT_WIDTH-1:0] mul_res;

   logic signed [ADD_SW-1:0]       add_sum;
   logic signed [ADD_XW-1:0]       add_ext;
   logic signed [ADD_XW-1:0]       add_scaled;
   logic signed [OUTPUT_WIDTH-1:0] add_res;

   logic [OUTPUT_WIDTH-1:0] mul_pipe_out;
   logic [OUTPUT_WIDTH-1:0] add_pipe_out;

   // Multiply, rescale (>>> floors toward -inf, <<< zero-fills), then saturate.
   // The whole calculation sits ahead of the first stage register.
   always_comb begin
      mul_prod   = MUL_PW'(mul_a) * MUL_PW'(mul_b);
      mul_ext    = MUL_XW'(mul_prod);
      mul_scaled = (mul_ext <<< MUL_LSH) >>> MUL_RSH;
      mul_res    = mul_scaled[OUTPUT_WIDTH-1:0];
      if (mul_scaled > MUL_XW'(OUT_MAX))
         mul_res = OUT_MAX;
      else if (mul_scaled < MUL_XW'(OUT_MIN))
         mul_res = OUT_MIN;
   end

   // Aligned add with a guard bit, rescale toward -inf, then saturate.
   always_comb begin
      add_sum    = (ADD_SW'(add_a) <<< ADD_ASH) + (ADD_SW'(add_b) <<< ADD_BSH);
      add_ext    = ADD_XW'(add_sum);
      add_scaled = (add_ext <<< ADD_LSH) >>> ADD_RSH;
      add_res    = add_scaled[OUTPUT_WIDTH-1:0];
      if (add_scaled > ADD_XW'(OUT_MAX))
         add_res = OUT_MAX;
      else if (add_scaled < ADD_XW'(OUT_MIN))
         add_res = OUT_MIN;
   end

   fxp_pipe #(
      .DEPTH (MUL_DELAY),
      .WIDTH (OUTPUT_WIDTH)
   ) u_mul_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .stall     (stall),
      .in_valid  (mul_en),
      .in_data   (mul_res),
      .out_data  (mul_pipe_out),
      .out_valid (mul_done)
   );

   fxp_pipe #(
      .DEPTH (ADD_DELAY),
      .WIDTH (OUTPUT_WIDTH)
   ) u_add_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .stall     (stall),
      .in_valid  (add_en),
      .in_data   (add_res),
      .out_data  (add_pipe_out),
      .out_valid (add_done)
   );

   // Present pipeline results as signed outputs.
   always_comb begin
      mul_out = mul_pipe_out;
      add_out = add_pipe_out;
   end

endmodule

// File: tb/tb_fxp_mul_add_unit.sv
// Directed bench for fxp_mul_add_unit at default Q8.8 parameters.
module tb_fxp_mul_add_unit;

   logic        clk = 1'b0;
   logic        rst_n, clear, stall;
   logic        mul_en, add_en;
   logic [15:0] mul_a, mul_b, add_a, add_b;
   logic [15:0] mul_out, add_out;
   logic        mul_done, add_done;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      bit          is_mul;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [13];

   fxp_mul_add_unit #(
      .INPUT_A_WIDTH (16),
      .INPUT_A_FRAC  (8),
      .INPUT_B_WIDTH (16),
      .INPUT_B_FRAC  (8),
      .OUTPUT_WIDTH  (16),
      .OUTPUT_FRAC   (8),
      .MUL_DELAY     (3),
      .ADD_DELAY     (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .stall    (stall),
      .mul_en   (mul_en),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_out  (mul_out),
      .mul_done (mul_done),
      .add_en   (add_en),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_out  (add_out),
      .add_done (add_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Launch one operation, then watch done and out through latency+1 edges.
   task automatic run_op(input bit is_mul, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input string name);
      int lat;
      lat = is_mul ? 3 : 1;
      @(negedge clk);
      if (is_mul) begin mul_en = 1'b1; mul_a = a; mul_b = b; end
      else        begin add_en = 1'b1; add_a = a; add_b = b; end
      for (int e = 1; e <= lat + 1; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin mul_en = 1'b0; add_en = 1'b0; end
         check($sformatf("%s done@%0d", name, e), {15'd0, is_mul ? mul_done : add_done},
               {15'd0, e == lat});
         if (e >= lat) check($sformatf("%s out@%0d", name, e), is_mul ? mul_out : add_out, exp);
      end
   endtask

   logic [15:0] bb_a   [4];
   logic [15:0] bb_b   [4];
   logic [15:0] bb_exp [4];

   initial begin
      vecs[0]  = '{1'b1, 16'h0180, 16'h0200, 16'h0300, "mul 1.5*2"};
      vecs[1]  = '{1'b1, 16'hFE80, 16'h0200, 16'hFD00, "mul -1.5*2"};
      vecs[2]  = '{1'b1, 16'h7F00, 16'h0200, 16'h7FFF, "mul sat pos"};
      vecs[3]  = '{1'b1, 16'h8000, 16'h7F00, 16'h8000, "mul sat neg"};
      vecs[4]  = '{1'b1, 16'h0001, 16'h0080, 16'h0000, "mul trunc pos"};
      vecs[5]  = '{1'b1, 16'hFFFF, 16'h0080, 16'hFFFF, "mul trunc neg"};
      vecs[6]  = '{1'b1, 16'h8000, 16'h8000, 16'h7FFF, "mul min*min"};
      vecs[7]  = '{1'b1, 16'h0100, 16'h0100, 16'h0100, "mul 1*1"};
      vecs[8]  = '{1'b0, 16'h0100, 16'h0280, 16'h0380, "add 1+2.5"};
      vecs[9]  = '{1'b0, 16'h7000, 16'h7000, 16'h7FFF, "add sat pos"};
      vecs[10] = '{1'b0, 16'h8000, 16'hFFFF, 16'h8000, "add sat neg"};
      vecs[11] = '{1'b0, 16'hFF00, 16'h0080, 16'hFF80, "add mixed"};
      vecs[12] = '{1'b0, 16'h7FFF, 16'h0000, 16'h7FFF, "add max+0"};

      bb_a[0] = 16'h0100; bb_b[0] = 16'h0200; bb_exp[0] = 16'h0200;
      bb_a[1] = 16'h0200; bb_b[1] = 16'h0300; bb_exp[1] = 16'h0600;
      bb_a[2] = 16'hFF00; bb_b[2] = 16'h0100; bb_exp[2] = 16'hFF00;
      bb_a[3] = 16'h0080; bb_b[3] = 16'h0080; bb_exp[3] = 16'h0040;

      rst_n = 1'b0; clear = 1'b0; stall = 1'b0;
      mul_en = 1'b0; add_en = 1'b0;
      mul_a = '0; mul_b = '0; add_a = '0; add_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset mul_out", mul_out, 16'h0000);
      check("reset mul_done", {15'd0, mul_done}, 16'h0000);
      check("reset add_out", add_out, 16'h0000);
      check("reset add_done", {15'd0, add_done}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++)
         run_op(vecs[i].is_mul, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      // Back-to-back multiplies, with an add launched alongside the first.
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         mul_en = (e <= 4);
         if (e <= 4) begin mul_a = bb_a[e-1]; mul_b = bb_b[e-1]; end
         add_en = (e == 1);
         add_a = 16'h0100; add_b = 16'h0280;
         @(posedge clk); #1;
         check($sformatf("b2b mul_done@%0d", e), {15'd0, mul_done}, {15'd0, e >= 3 && e <= 6});
         if (e >= 3 && e <= 6) check($sformatf("b2b mul_out@%0d", e), mul_out, bb_exp[e-3]);
         check($sformatf("b2b add_done@%0d", e), {15'd0, add_done}, {15'd0, e == 1});
         check($sformatf("b2b add_out@%0d", e), add_out, 16'h0380);
      end
      check("b2b mul_out hold", mul_out, 16'h0040);

      // Stall for two cycles mid-flight; a launch attempted during stall is ignored.
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk);
         stall  = (e == 2 || e == 3);
         mul_en = (e == 1 || e == 2);
         mul_a  = (e == 1) ? 16'h0180 : 16'h0100;
         mul_b  = (e == 1) ? 16'h0200 : 16'h0100;
         @(posedge clk); #1;
         check($sformatf("stall mul_done@%0d", e), {15'd0, mul_done}, {15'd0, e == 5});
         check($sformatf("stall mul_out@%0d", e), mul_out, (e >= 5) ? 16'h0300 : 16'h0040);
      end
      @(negedge clk);
      stall = 1'b0; mul_en = 1'b0;

      // Synchronous clear one cycle after launch.
      @(negedge clk);
      mul_en = 1'b1; mul_a = 16'h0100; mul_b = 16'h0200;
      @(negedge clk);
      mul_en = 1'b0; clear = 1'b1;
      @(posedge clk); #1;
      check("clear mul_out", mul_out, 16'h0000);
      check("clear add_out", add_out, 16'h0000);
      @(negedge clk);
      clear = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         check($sformatf("clear no done@%0d", e), {15'd0, mul_done}, 16'h0000);
         check($sformatf("clear out@%0d", e), mul_out, 16'h0000);
      end

      // Asynchronous reset one cycle after launch, with results already held.
      run_op(1'b1, 16'h0180, 16'h0200, 16'h0300, "pre-rst mul");
      run_op(1'b0, 16'h0100, 16'h0280, 16'h0380, "pre-rst add");
      @(negedge clk);
      mul_en = 1'b1; mul_a = 16'h0200; mul_b = 16'h0200;
      @(negedge clk);
      mul_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst async mul_out", mul_out, 16'h0000);
      check("rst async add_out", add_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         check($sformatf("rst no done@%0d", e), {15'd0, mul_done}, 16'h0000);
         check($sformatf("rst out@%0d", e), mul_out, 16'h0000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
